// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - data-memory port bundle between the MEM stage and the responder
//
// Signals:
//   dmemaddr   byte address (bit 0 must be 0 for a valid access)
//   dmemwdata  write data
//   dmemwrite  write enable for this cycle
//   dmemread   read enable for this cycle
//   dmemrdata  read data, combinational from the address
// Modports: master (pipeline side), slave (memory responder side).
interface dmem_responder_if;
    logic [15:0] dmemaddr;
    logic [15:0] dmemwdata;
    logic        dmemwrite;
    logic        dmemread;
    logic [15:0] dmemrdata;

    modport master (
        output dmemaddr,
        output dmemwdata,
        output dmemwrite,
        output dmemread,
        input  dmemrdata
    );

    modport slave (
        input  dmemaddr,
        input  dmemwdata,
        input  dmemwrite,
        input  dmemread,
        output dmemrdata
    );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - zero-wait-state data memory with LED/switch/counter I/O page
//
// Ports:
//   clock     system clock, rising edge
//   reset     asynchronous, active-high
//   bus       dmem_responder_if.slave: address, write data, read/write strobes, read data
//   switches  asynchronous external inputs, double-flop synchronised
//   leds      LED register
//   irq       match AND irq_en
module dmem_responder #(
    parameter int          ADDR_W  = 7,
    parameter logic [15:0] IO_BASE = 16'hFFF0
) (
    input  logic              clock,
    input  logic              reset,
    dmem_responder_if.slave   bus,
    input  logic [7:0]        switches,
    output logic [7:0]        leds,
    output logic              irq
);

    // Word index within the I/O page (byte offset / 2).
    localparam logic [2:0] REG_LEDS   = 3'd0;
    localparam logic [2:0] REG_SW     = 3'd1;
    localparam logic [2:0] REG_COUNT  = 3'd2;
    localparam logic [2:0] REG_CMP    = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;

    logic [15:0] mem [0:(1 << ADDR_W) - 1];

    logic [7:0]  sw_meta;
    logic [7:0]  sw_sync;
    logic [15:0] count;
    logic [15:0] cmp;
    logic        match;
    logic        misalign;
    logic        irq_en;

    logic              io_sel;
    logic [2:0]        reg_sel;
    logic [ADDR_W-1:0] ram_idx;
    logic              aligned;
    logic              io_wr;
    logic              ram_wr;
    logic              status_wr;
    logic              match_hit;
    logic              misalign_evt;
    logic [15:0]       rdata;

    assign io_sel    = (bus.dmemaddr[15:4] == IO_BASE[15:4]);
    assign reg_sel   = bus.dmemaddr[3:1];
    assign ram_idx   = bus.dmemaddr[ADDR_W:1];
    assign aligned   = ~bus.dmemaddr[0];
    assign io_wr     = bus.dmemwrite & aligned & io_sel;
    assign ram_wr    = bus.dmemwrite & aligned & ~io_sel;
    assign status_wr = io_wr & (reg_sel == REG_STATUS);

    // Compare against the registered counter; the flag lands one edge later.
    assign match_hit    = (count == cmp);
    assign misalign_evt = bus.dmemaddr[0] & (bus.dmemwrite | bus.dmemread);

    // Read path sees pre-edge state, so a simultaneous write returns the old value.
    always_comb begin
        rdata = 16'h0000;
        if (bus.dmemread && aligned) begin
            if (io_sel) begin
                case (reg_sel)
                    REG_LEDS:   rdata = {8'h00, leds};
                    REG_SW:     rdata = {8'h00, sw_sync};
                    REG_COUNT:  rdata = count;
                    REG_CMP:    rdata = cmp;
                    REG_STATUS: rdata = {13'h0000, irq_en, misalign, match};
                    default:    rdata = 16'h0000;
                endcase
            end else begin
                rdata = mem[ram_idx];
            end
        end
    end

    assign bus.dmemrdata = rdata;
    assign irq           = match & irq_en;

    // RAM contents survive reset.
    always_ff @(posedge clock) begin
        if (ram_wr) begin
            mem[ram_idx] <= bus.dmemwdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sw_meta  <= 8'h00;
            sw_sync  <= 8'h00;
            leds     <= 8'h00;
            count    <= 16'h0000;
            cmp      <= 16'h0000;
            match    <= 1'b0;
            misalign <= 1'b0;
            irq_en   <= 1'b0;
        end else begin
            sw_meta <= switches;
            sw_sync <= sw_meta;

            if (io_wr && reg_sel == REG_COUNT) begin
                count <= bus.dmemwdata;
            end else begin
                count <= count + 16'd1;
            end

            if (io_wr && reg_sel == REG_LEDS) begin
                leds <= bus.dmemwdata[7:0];
            end

            if (io_wr && reg_sel == REG_CMP) begin
                cmp <= bus.dmemwdata;
            end

            if (status_wr) begin
                irq_en <= bus.dmemwdata[2];
            end

            // Set has priority over a write-1-to-clear in the same cycle.
            match    <= match_hit | (match & ~(status_wr & bus.dmemwdata[0]));
            misalign <= misalign_evt | (misalign & ~(status_wr & bus.dmemwdata[1]));
        end
    end

endmodule
